spi_ureg_writer: RTL and testbench

- SPI slave (mode 0, MSB first) that owns the 8×16-bit user register bank.
- Deserializes host frames and drives the packed 128-bit user_register_o bus consumed by the command-latch stage.
- Optionally serializes register contents back to the host on MISO.
- All logic runs in the system clock domain; SPI pins are oversampled.

---
 rtl/spi_ureg_writer.sv | 104 ++++++++++
 tb/tb_spi_ureg_writer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/spi_ureg_writer.sv
// spi_ureg_writer: SPI mode-0 slave that owns the 8x16-bit user register bank.
// Ports: clk/rst (sync, active-low); spi_sclk/spi_cs_n/spi_mosi async SPI inputs;
//   spi_miso/spi_miso_oe readback outputs; reg_lock blocks host writes;
//   user_register_o packed bank (addr a at [16a+15:16a]); wr_strobe/wr_addr
//   report commits; wr_reject sticky error cleared by wr_reject_clr.
// Build option: define SPI_READBACK_EN to serialize read frames onto spi_miso.
module spi_ureg_writer #(
    parameter int SYNC_STAGES = 2,
    parameter logic [127:0] RST_VALUE = 128'h0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         spi_sclk,
    input  logic         spi_cs_n,
    input  logic         spi_mosi,
    output logic         spi_miso,
    output logic         spi_miso_oe,
    input  logic         reg_lock,
    output logic [127:0] user_register_o,
    output logic         wr_strobe,
    output logic [2:0]   wr_addr,
    output logic         wr_reject,
    input  logic         wr_reject_clr
);
    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
    logic [7:0][15:0] bank;
    logic [22:0] sh;
    logic [23:0] frame;
    logic [4:0] cnt;
    logic sclk_s, cs_s, mosi_s, sclk_d, sclk_rise, armed, shifting, last, commit;
    assign sclk_s = sclk_sr[SYNC_STAGES-1];
    assign cs_s = cs_sr[SYNC_STAGES-1];
    assign mosi_s = mosi_sr[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign frame = {sh, mosi_s};
    assign shifting = (state == CMD || state == DATA) && sclk_rise;
    assign last = state == DATA && sclk_rise && cnt == 5'd23 && !cs_s;
    assign commit = last && frame[23] && frame[22:19] == 4'd0 && !reg_lock;
    assign user_register_o = bank;
    // armed stays low after reset until cs_n is seen high, so a frame cut by reset is never resumed
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            {sclk_sr, mosi_sr, cs_sr} <= '0;
            sclk_d <= 1'b0;
            armed <= 1'b0;
            cnt <= 5'd0;
            sh <= '0;
            bank <= RST_VALUE;
            wr_strobe <= 1'b0;
            wr_addr <= 3'd0;
            wr_reject <= 1'b0;
        end else begin
            state <= state_n;
            sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
            cs_sr <= {cs_sr[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
            sclk_d <= sclk_s;
            armed <= armed | cs_s;
            cnt <= state == IDLE ? 5'd0 : shifting ? cnt + 5'd1 : cnt;
            if (shifting) sh <= frame[22:0];
            wr_strobe <= commit;
            if (commit) begin
                bank[frame[18:16]] <= frame[15:0];
                wr_addr <= frame[18:16];
            end
            wr_reject <= (last && frame[23] && !commit) | (wr_reject & ~wr_reject_clr);
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = armed && !cs_s ? CMD : IDLE;
            CMD:  state_n = cs_s ? IDLE : sclk_rise && cnt == 5'd7 ? DATA : CMD;
            DATA: state_n = cs_s ? IDLE : last ? DONE : DATA;
            DONE: state_n = cs_s ? IDLE : DONE;
        endcase
    end
`ifdef SPI_READBACK_EN
    logic [15:0] so;
    logic rd, sclk_fall;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign spi_miso_oe = armed & ~cs_s;
    always_ff @(posedge clk) begin
        if (!rst) begin
            so <= 16'd0;
            rd <= 1'b0;
            spi_miso <= 1'b0;
        end else begin
            if (state == CMD && sclk_rise && cnt == 5'd7) begin
                rd <= ~frame[7];
                so <= bank[frame[2:0]];
            end
            if (state == DATA && rd && sclk_fall) so <= {so[14:0], 1'b0};
            spi_miso <= state == DATA && rd ? (sclk_fall ? so[15] : spi_miso) : 1'b0;
        end
    end
`else
    assign spi_miso = 1'b0;
    assign spi_miso_oe = 1'b0;
`endif
endmodule

// File: tb/tb_spi_ureg_writer.sv
// tb_spi_ureg_writer: directed scoreboard bench for spi_ureg_writer.
module tb_spi_ureg_writer;
    logic clk = 1'b0, rst = 1'b0;
    logic spi_sclk = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic spi_miso, spi_miso_oe, reg_lock = 1'b0, wr_reject_clr = 1'b0;
    logic [127:0] user_register_o;
    logic wr_strobe, wr_reject;
    logic [2:0] wr_addr;
    int checks = 0, errors = 0;
    logic [7:0][15:0] mb = '0;
    logic [18:0] q[$];
    logic prev_strobe = 1'b0;
    logic [15:0] rd;
    logic oe_mid;

    spi_ureg_writer dut (
        .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .reg_lock(reg_lock), .user_register_o(user_register_o),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_reject(wr_reject),
        .wr_reject_clr(wr_reject_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [23:0] f, input int nbits, output logic [15:0] r, output logic oe);
        r = '0;
        oe = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = i < 24 ? f[23-i] : 1'b0;
            clks(5);
            if (i >= 8 && i < 24) r[23-i] = spi_miso;
            if (i == 12) oe = spi_miso_oe;
            spi_sclk = 1'b1;
            clks(5);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [15:0] data, input int nbits);
        spi_cs_n = 1'b0;
        clks(5);
        send_bits({cmd, data}, nbits, rd, oe_mid);
        clks(5);
        spi_cs_n = 1'b1;
        clks(8);
    endtask

    task automatic expect_write(input logic [7:0] cmd, input logic [15:0] data);
        q.push_back({cmd[2:0], data});
        mb[cmd[2:0]] = data;
    endtask

    // Monitor: every strobe must match the oldest expected commit and last one cycle.
    always @(negedge clk) begin
        if (rst && wr_strobe) begin
            if (prev_strobe) begin
                checks++;
                errors++;
                $display("FAIL strobe_width: wr_strobe high on consecutive cycles");
            end else if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: wr_addr=%0d with no commit expected", wr_addr);
            end else begin
                logic [18:0] e;
                e = q.pop_front();
                chk("commit_addr", 128'(wr_addr), 128'(e[18:16]));
                chk("commit_data", 128'(user_register_o[16*e[18:16] +: 16]), 128'(e[15:0]));
            end
        end
        prev_strobe <= wr_strobe;
    end

    initial begin
        clks(3);
        chk("reset_bank", user_register_o, 128'h0);
        chk("reset_strobe", 128'(wr_strobe), 128'h0);
        chk("reset_reject", 128'(wr_reject), 128'h0);
        chk("reset_oe", 128'(spi_miso_oe), 128'h0);
        chk("reset_addr", 128'(wr_addr), 128'h0);
        rst = 1'b1;
        clks(5);

        expect_write(8'h87, 16'h1234);
        frame(8'h87, 16'h1234, 24);
        chk("w7_bank", user_register_o, mb);
        chk("w7_addr", 128'(wr_addr), 128'd7);
        chk("w7_reject", 128'(wr_reject), 128'h0);

        reg_lock = 1'b1;
        frame(8'h80, 16'hFFFF, 24);
        reg_lock = 1'b0;
        chk("lock_bank", user_register_o, mb);
        chk("lock_reject", 128'(wr_reject), 128'h1);
        wr_reject_clr = 1'b1;
        clks(1);
        wr_reject_clr = 1'b0;
        clks(1);
        chk("reject_clr", 128'(wr_reject), 128'h0);

        frame(8'h83, 16'h00AA, 12);
        chk("abort_bank", user_register_o, mb);
        chk("abort_reject", 128'(wr_reject), 128'h0);
        expect_write(8'h83, 16'h00AA);
        frame(8'h83, 16'h00AA, 24);
        chk("w3_bank", user_register_o, mb);

        frame(8'hC1, 16'h5555, 24);
        chk("rsvd_bank", user_register_o, mb);
        chk("rsvd_reject", 128'(wr_reject), 128'h1);

        frame(8'h07, 16'h0000, 24);
        chk("read_keeps_reject", 128'(wr_reject), 128'h1);
        chk("read_bank", user_register_o, mb);
        wr_reject_clr = 1'b1;
        clks(1);
        wr_reject_clr = 1'b0;
        clks(1);
        chk("reject_clr2", 128'(wr_reject), 128'h0);

        expect_write(8'h84, 16'hA5C3);
        frame(8'h84, 16'hA5C3, 30);
        chk("w30_bank", user_register_o, mb);

`ifdef SPI_READBACK_EN
        expect_write(8'h82, 16'hBEEF);
        frame(8'h82, 16'hBEEF, 24);
        frame(8'h02, 16'h0000, 24);
        chk("read2_data", 128'(rd), 128'hBEEF);
        chk("read_oe_active", 128'(oe_mid), 128'h1);
        chk("oe_idle", 128'(spi_miso_oe), 128'h0);
        frame(8'h04, 16'h0000, 24);
        chk("read4_data", 128'(rd), 128'hA5C3);
        frame(8'h82, 16'h1111, 24);
        mb[2] = 16'h1111;
        q.push_back({3'd2, 16'h1111});
        chk("write_miso_zero", 128'(rd), 128'h0);
`else
        frame(8'h07, 16'h0000, 24);
        chk("read_miso_tied", 128'(rd), 128'h0);
        chk("read_oe_tied", 128'(oe_mid), 128'h0);
`endif

        // Reset mid-frame, then a complete write without releasing cs_n: must be ignored.
        spi_cs_n = 1'b0;
        clks(5);
        send_bits(24'h861111, 10, rd, oe_mid);
        rst = 1'b0;
        clks(2);
        rst = 1'b1;
        mb = '0;
        chk("midreset_bank", user_register_o, 128'h0);
        send_bits(24'h862222, 24, rd, oe_mid);
        clks(5);
        spi_cs_n = 1'b1;
        clks(8);
        chk("midreset_nocommit", user_register_o, 128'h0);
        expect_write(8'h85, 16'h7777);
        frame(8'h85, 16'h7777, 24);
        chk("post_reset_write", user_register_o, mb);
        chk("queue_drained", 128'(q.size()), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
